// File: rtl/otp_stream_cryptor_pkg.sv
// Shared constants and types for the one-time-pad stream cryptor.
//   KEY_SIZE    : default width of message and key words
//   otp_state_e : framing FSM encodings (IDLE / MSG / STALL)
package otp_stream_cryptor_pkg;

  localparam int KEY_SIZE = 16;

  typedef enum logic [1:0] {
    OTP_IDLE  = 2'd0,
    OTP_MSG   = 2'd1,
    OTP_STALL = 2'd2
  } otp_state_e;

endpackage

// File: rtl/otp_stream_cryptor_key_fifo.sv
// Key word buffer: first-word-fall-through FIFO.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (empties the buffer)
//   push_i       : write data_i (ignored while full, even with a same-cycle pop)
//   data_i       : key word to store
//   pop_i        : discard the head word (caller guarantees non-empty)
//   head_o       : oldest stored word, valid whenever !empty_o
//   full_o       : DEPTH words stored
//   empty_o      : no words stored
//   level_o      : number of stored words, 0..DEPTH
module otp_key_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              push_ok;
  logic              pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/otp_stream_cryptor.sv
// Streaming one-time-pad encryptor/decryptor (encrypt == decrypt).
// Each accepted message word is XORed with the oldest buffered key word,
// which is then discarded so it is never reused.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   key_valid/key_ready/key_data  : key word input stream
//   in_valid/in_ready/in_data/in_last : message word input stream
//   out_valid/out_ready/out_data/out_last : result stream (registered)
//   starved   : sticky, a frame stalled mid-message on an empty key buffer
//   key_level : key words buffered, 0..KEY_DEPTH
//   key_used  : key words consumed, saturating at all-ones
//   state_o   : framing FSM state (otp_state_e encoding), for observation
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. A source holds valid and its payload stable until
// the transfer; ready may change freely. key_ready depends only on
// registered state; in_ready depends on registered state and out_ready.
module otp_stream_cryptor
  import otp_stream_cryptor_pkg::*;
#(
  parameter int DATA_W    = KEY_SIZE,
  parameter int KEY_DEPTH = 8,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        key_valid,
  output logic                        key_ready,
  input  logic [DATA_W-1:0]           key_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_last,
  output logic                        starved,
  output logic [$clog2(KEY_DEPTH):0]  key_level,
  output logic [CNT_W-1:0]            key_used,
  output logic [1:0]                  state_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] key_head;
  logic              fire;

  otp_state_e        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              starved_q, starved_d;
  logic [CNT_W-1:0]  key_used_q, key_used_d;

  otp_key_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (KEY_DEPTH)
  ) u_key_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (key_valid & key_ready),
    .data_i  (key_data),
    .pop_i   (fire),
    .head_o  (key_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (key_level)
  );

  assign key_ready = ~fifo_full;
  // A word can be taken when a key exists and the output slot is free or
  // is being drained in the same cycle.
  assign in_ready  = ~fifo_empty & (~out_valid_q | out_ready);
  assign fire      = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    starved_d   = starved_q;
    key_used_d  = key_used_q;

    if (fire) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ key_head;
      out_last_d  = in_last;
      if (key_used_q != '1) key_used_d = key_used_q + CNT_ONE;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      OTP_IDLE: begin
        // An empty buffer between frames is not starvation.
        if (fire && !in_last) state_d = OTP_MSG;
      end
      OTP_MSG: begin
        if (fire) begin
          if (in_last) state_d = OTP_IDLE;
        end else if (in_valid && fifo_empty) begin
          // Only a key shortage counts; output back-pressure does not.
          state_d   = OTP_STALL;
          starved_d = 1'b1;
        end
      end
      OTP_STALL: begin
        if (fire) state_d = in_last ? OTP_IDLE : OTP_MSG;
      end
      default: state_d = OTP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= OTP_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      starved_q   <= 1'b0;
      key_used_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      starved_q   <= starved_d;
      key_used_q  <= key_used_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign starved   = starved_q;
  assign key_used  = key_used_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_otp_stream_cryptor.sv
// Directed bench for otp_stream_cryptor (DATA_W=16, KEY_DEPTH=8, CNT_W=4 so
// that key_used saturation is reached within the run).
module tb_otp_stream_cryptor;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic        key_ready;
  logic [15:0] key_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        starved;
  logic [3:0]  key_level;
  logic [3:0]  key_used;
  logic [1:0]  state;

  int total;
  int bad;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MSG   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  otp_stream_cryptor #(
    .DATA_W    (16),
    .KEY_DEPTH (8),
    .CNT_W     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_data  (key_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .starved   (starved),
    .key_level (key_level),
    .key_used  (key_used),
    .state_o   (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Advance to 1 time unit after the next rising edge; inputs driven here
  // are sampled on the following edge, outputs read here are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_key(input logic [15:0] k);
    key_valid = 1'b1;
    key_data  = k;
    tick();
    key_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; key_valid = 0; key_data = 0; in_valid = 0; in_data = 0;
    in_last = 0; out_ready = 1'b1;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL reset_out_data got=%h want=0000", out_data); end
    total++; if (key_level !== 4'd0) begin bad++; $display("FAIL reset_key_level got=%0d want=0", key_level); end
    total++; if (key_used !== 4'd0) begin bad++; $display("FAIL reset_key_used got=%0d want=0", key_used); end
    total++; if (starved !== 1'b0) begin bad++; $display("FAIL reset_starved got=%b want=0", starved); end
    total++; if (state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL reset_key_ready got=%b want=1", key_ready); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    push_key(16'hFFFF);
    in_valid = 1'b1; in_data = 16'h0000; in_last = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid got=%b want=1", out_valid); end
    total++; if (out_data !== 16'hFFFF) begin bad++; $display("FAIL single_out_data got=%h want=ffff", out_data); end
    total++; if (out_last !== 1'b1) begin bad++; $display("FAIL single_out_last got=%b want=1", out_last); end
    total++; if (key_used !== 4'd1) begin bad++; $display("FAIL single_key_used got=%0d want=1", key_used); end
    total++; if (key_level !== 4'd0) begin bad++; $display("FAIL single_key_level got=%0d want=0", key_level); end
    total++; if (state !== S_IDLE) begin bad++; $display("FAIL single_state got=%0d want=0", state); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    push_key(16'h5555);
    push_key(16'h5555);
    in_valid = 1'b1; in_data = 16'hAAAA; in_last = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready0 got=%b want=1", in_ready); end
    tick();
    total++; if (out_data !== 16'hFFFF) begin bad++; $display("FAIL b2b_data0 got=%h want=ffff", out_data); end
    total++; if (state !== S_MSG) begin bad++; $display("FAIL b2b_state0 got=%0d want=1", state); end
    in_data = 16'hFFFF; in_last = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready1 got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (out_data !== 16'hAAAA) begin bad++; $display("FAIL b2b_data1 got=%h want=aaaa", out_data); end
    total++; if (out_last !== 1'b1) begin bad++; $display("FAIL b2b_last1 got=%b want=1", out_last); end
    total++; if (state !== S_IDLE) begin bad++; $display("FAIL b2b_state1 got=%0d want=0", state); end
    total++; if (key_used !== 4'd3) begin bad++; $display("FAIL b2b_key_used got=%0d want=3", key_used); end
    tick();
  endtask

  task automatic test_full();
    logic [15:0] exp_d;
    for (int i = 0; i < 8; i++) push_key(16'h1000 + 16'(i));
    total++; if (key_ready !== 1'b0) begin bad++; $display("FAIL full_key_ready got=%b want=0", key_ready); end
    total++; if (key_level !== 4'd8) begin bad++; $display("FAIL full_key_level got=%0d want=8", key_level); end
    // Offer a key while popping: must be refused because the buffer is full.
    key_valid = 1'b1; key_data = 16'hBEEF;
    in_valid = 1'b1; in_data = 16'h0000; in_last = 1'b1;
    tick();
    key_valid = 1'b0;
    total++; if (key_level !== 4'd7) begin bad++; $display("FAIL full_pushpop_level got=%0d want=7", key_level); end
    total++; if (out_data !== 16'h1000) begin bad++; $display("FAIL full_first_data got=%h want=1000", out_data); end
    for (int i = 1; i < 8; i++) begin
      in_data = 16'h00F0;
      tick();
      exp_d = (16'h1000 + 16'(i)) ^ 16'h00F0;
      total++; if (out_data !== exp_d) begin bad++; $display("FAIL full_drain_data%0d got=%h want=%h", i, out_data, exp_d); end
    end
    in_valid = 1'b0;
    tick();
    total++; if (key_level !== 4'd0) begin bad++; $display("FAIL full_end_level got=%0d want=0", key_level); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_end_valid got=%b want=0", out_valid); end
    total++; if (key_used !== 4'd11) begin bad++; $display("FAIL full_key_used got=%0d want=11", key_used); end
  endtask

  task automatic test_starve();
    push_key(16'h1111);
    push_key(16'h2222);
    in_valid = 1'b1; in_data = 16'h0001; in_last = 1'b0;
    tick();
    total++; if (out_data !== 16'h1110) begin bad++; $display("FAIL starve_data0 got=%h want=1110", out_data); end
    in_data = 16'h0002;
    tick();
    total++; if (out_data !== 16'h2220) begin bad++; $display("FAIL starve_data1 got=%h want=2220", out_data); end
    total++; if (starved !== 1'b0) begin bad++; $display("FAIL starve_early got=%b want=0", starved); end
    in_data = 16'h0003; in_last = 1'b1;
    tick();
    total++; if (state !== S_STALL) begin bad++; $display("FAIL starve_state got=%0d want=2", state); end
    total++; if (starved !== 1'b1) begin bad++; $display("FAIL starve_flag got=%b want=1", starved); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL starve_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL starve_out_valid got=%b want=0", out_valid); end
    push_key(16'h3333);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL starve_resume_ready got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (out_data !== 16'h3330) begin bad++; $display("FAIL starve_data2 got=%h want=3330", out_data); end
    total++; if (out_last !== 1'b1) begin bad++; $display("FAIL starve_last got=%b want=1", out_last); end
    total++; if (state !== S_IDLE) begin bad++; $display("FAIL starve_end_state got=%0d want=0", state); end
    total++; if (starved !== 1'b1) begin bad++; $display("FAIL starve_sticky got=%b want=1", starved); end
    total++; if (key_used !== 4'd14) begin bad++; $display("FAIL starve_key_used got=%0d want=14", key_used); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_q[$];
    logic [15:0] exp_d;
    push_key(16'hA0A0);
    push_key(16'h0B0B);
    push_key(16'hC0C0);
    push_key(16'h0D0D);
    exp_q.push_back(16'hA0AF);
    exp_q.push_back(16'h0BFB);
    exp_q.push_back(16'hCFC0);
    exp_q.push_back(16'hFD0D);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h000F; in_last = 1'b0;
    tick();
    in_data = 16'h00F0;
    tick();
    tick();
    total++; if (out_data !== 16'hA0AF) begin bad++; $display("FAIL bp_hold_data got=%h want=a0af", out_data); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%b want=1", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    total++; if (key_level !== 4'd3) begin bad++; $display("FAIL bp_key_level got=%0d want=3", key_level); end
    total++; if (state !== S_MSG) begin bad++; $display("FAIL bp_state got=%0d want=1", state); end
    exp_d = exp_q.pop_front();
    total++; if (out_data !== exp_d) begin bad++; $display("FAIL bp_word0 got=%h want=%h", out_data, exp_d); end
    out_ready = 1'b1;
    tick();
    exp_d = exp_q.pop_front();
    total++; if (out_data !== exp_d) begin bad++; $display("FAIL bp_word1 got=%h want=%h", out_data, exp_d); end
    in_data = 16'h0F00;
    tick();
    exp_d = exp_q.pop_front();
    total++; if (out_data !== exp_d) begin bad++; $display("FAIL bp_word2 got=%h want=%h", out_data, exp_d); end
    in_data = 16'hF000; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_d = exp_q.pop_front();
    total++; if (out_data !== exp_d) begin bad++; $display("FAIL bp_word3 got=%h want=%h", out_data, exp_d); end
    total++; if (out_last !== 1'b1) begin bad++; $display("FAIL bp_last got=%b want=1", out_last); end
    total++; if (state !== S_IDLE) begin bad++; $display("FAIL bp_end_state got=%0d want=0", state); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_end_valid got=%b want=0", out_valid); end
    total++; if (key_level !== 4'd0) begin bad++; $display("FAIL bp_end_level got=%0d want=0", key_level); end
    total++; if (key_used !== 4'd15) begin bad++; $display("FAIL bp_key_used_sat got=%0d want=15", key_used); end
  endtask

  task automatic test_async_reset();
    push_key(16'h7777);
    push_key(16'h8888);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0101; in_last = 1'b0;
    tick();
    total++; if (out_data !== 16'h7676) begin bad++; $display("FAIL ar_pre_data got=%h want=7676", out_data); end
    total++; if (key_used !== 4'd15) begin bad++; $display("FAIL ar_pre_used_hold got=%0d want=15", key_used); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_out_valid got=%b want=0", out_valid); end
    total++; if (key_level !== 4'd0) begin bad++; $display("FAIL ar_key_level got=%0d want=0", key_level); end
    total++; if (key_used !== 4'd0) begin bad++; $display("FAIL ar_key_used got=%0d want=0", key_used); end
    total++; if (starved !== 1'b0) begin bad++; $display("FAIL ar_starved got=%b want=0", starved); end
    total++; if (state !== S_IDLE) begin bad++; $display("FAIL ar_state got=%0d want=0", state); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_post_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ar_post_in_ready got=%b want=0", in_ready); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_full();
    test_starve();
    test_backpressure();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/otp_stream_cryptor.md
Name: otp_stream_cryptor

Overview:
- Streaming one-time-pad encryptor/decryptor; successor to the single-word XOR cryptor.
- Holds a buffer of key words. XORs each accepted message word with the oldest unused key word, then discards that key word so it is never reused.
- Valid/ready handshakes on key, message and output. Message framing via last flags. Tracks key starvation and consumption.
- Sits between the message source and the link. Encrypt and decrypt are the same operation.

Parameters:
- DATA_W, default `KEY_SIZE (16): width of message and key words.
- KEY_DEPTH, default 8: key buffer depth in words; power of two, ≥2.
- CNT_W, default 16: width of the consumed-key counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- key_valid  in  1  key word offered
- key_ready  out  1  key buffer can accept
- key_data  in  DATA_W  key word
- in_valid  in  1  message word offered
- in_ready  out  1  message word accepted this cycle when in_valid is also high
- in_data  in  DATA_W  message word
- in_last  in  1  final word of message
- out_valid  out  1  result word held
- out_ready  in  1  sink accepts result
- out_data  out  DATA_W  in_data XOR key word
- out_last  out  1  copy of in_last for this word
- starved  out  1  sticky: a message stalled mid-frame because the key buffer was empty
- key_level  out  $clog2(KEY_DEPTH)+1  key words buffered
- key_used  out  CNT_W  total key words consumed, saturating

Behaviour:
- Reset (async, rst=1): key buffer empty. out_valid=0, out_data=0, out_last=0, starved=0, key_level=0, key_used=0, FSM=IDLE. Effect is immediate and applies mid-message; any in-flight word is dropped.
- Key buffer: FIFO with DATA_W × KEY_DEPTH storage. Pointers carry one extra wrap bit; full and empty are decoded from them.
  - key_ready = !full. Push occurs when key_valid & key_ready.
  - When full, a push is refused even if a pop happens in the same cycle. key_ready depends only on registered state.
  - Simultaneous push and pop when not full: key_level is unchanged; the head advances and the tail advances.
- Message accept:
  - in_ready = !empty & (!out_valid | out_ready).
  - fire = in_valid & in_ready.
  - On fire, at the next edge: out_data ← in_data ^ head key, out_last ← in_last, out_valid ← 1. The key is popped.
  - If key_used < 2^CNT_W−1, key_used increments by 1; otherwise it holds at all-ones.
- Latency: exactly 1 cycle from fire to out_valid. Full throughput: 1 word/cycle while key is available and out_ready=1.
- Output: out_valid clears when out_ready=1 and no new fire occurs. out_data and out_last hold stable while out_valid=1 and out_ready=0.
- FSM:
  - IDLE → MSG on fire with in_last=0. Fire with in_last=1 (single-word message) stays in IDLE.
  - MSG → IDLE on fire with in_last=1.
  - MSG → STALL when in_valid=1 and the buffer is empty. In this transition starved is set and stays set until reset.
  - STALL → MSG when the buffer becomes non-empty and the next word fires with in_last=0. If that word has in_last=1, STALL → IDLE.
  - An empty buffer while in IDLE does not set starved.
  - Output back-pressure alone never sets starved.
- Width: XOR is bitwise over DATA_W, with no carry. key_level ranges 0..KEY_DEPTH inclusive.

Decomposition:
- Shared constants header: existing `KEY_SIZE, plus FSM encodings `OTP_IDLE=2'd0, `OTP_MSG=2'd1, `OTP_STALL=2'd2.
- Sub-module: otp_key_fifo(DATA_W, DEPTH). Provides push/pop, head data (first-word-fall-through), full, empty, level.
- Top-level contents: handshake logic, output register, FSM, counter.

Test Plan:
- Reset, then push key 16'hFFFF and send msg 16'h0000 with last=1 → one cycle later out_data=16'hFFFF, out_last=1, key_used=1, key_level=0, state IDLE.
- Push keys 16'h5555, 16'h5555 and send msgs 16'hAAAA, 16'hFFFF back-to-back with out_ready=1 → out_data=16'hFFFF then 16'hAAAA on consecutive cycles, in_ready high on both fires.
- Fill buffer with 8 keys → key_ready=0, key_level=8. Hold key_valid=1 while popping one word the same cycle → no push, key_level=7.
- Send 3-word message with 2 keys buffered → 2 words out, state STALL, starved=1, in_ready=0. Push 1 key → third word fires, out_last=1, state IDLE, starved still 1.
- Hold out_ready=0 with 4 keys and continuous in_valid → one word accepted, out_data stable, in_ready=0, key_level=3. Release out_ready → streaming resumes with no loss or duplication.
- Assert rst asynchronously mid-message → out_valid=0, key_level=0, key_used=0, starved=0 immediately, without waiting for a clock edge.
